// File: rtl/sram22_ctrl_pkg.sv
// sram22_ctrl_pkg: shared widths, FSM states and request layout for the SRAM22 64x24 front end
package sram22_ctrl_pkg;
  localparam int DATA_WIDTH = 24;
  localparam int ADDR_WIDTH = 6;
  typedef enum logic {CLEAR, RUN} ctrl_state_e;
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;
endpackage

// File: rtl/sram22_rsp_fifo.sv
// sram22_rsp_fifo: synchronous response FIFO whose output holds the last popped word when empty
module sram22_rsp_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [WIDTH-1:0] last_q;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign dout = count != '0 ? mem[rptr] : last_q;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      last_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        last_q <= mem[rptr];
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && 32'(count) == DEPTH));
endmodule

// File: rtl/sram22_64x24_ctrl.sv
// sram22_64x24_ctrl: valid/ready front end for the SRAM22 64x24 macro with post-reset zero fill
module sram22_64x24_ctrl #(
  parameter int DATA_WIDTH     = sram22_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = sram22_ctrl_pkg::ADDR_WIDTH,
  parameter int RSP_DEPTH      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  clear_done,
  output logic                  sram_we,
  output logic                  sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  import sram22_ctrl_pkg::*;
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  ctrl_state_e state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic rd_pin, rd_cap, read_ok, accept;
  logic [CW-1:0] fifo_cnt;
  req_t req;
  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata};
  // Credit counts every read that will land in the FIFO, so a push can never overflow it.
  assign read_ok = 32'(fifo_cnt) + 32'(rd_pin) + 32'(rd_cap) < RSP_DEPTH;
  assign req_ready = state == RUN && (req.we || read_ok);
  assign accept = req_valid && req_ready;
  assign rsp_valid = fifo_cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      clear_done <= !CLEAR_ON_RESET;
      clr_cnt <= '0;
      sram_we <= 1'b0;
      sram_wmask <= 1'b0;
      sram_addr <= '0;
      sram_din <= '0;
      rd_pin <= 1'b0;
      rd_cap <= 1'b0;
    end else begin
      rd_cap <= rd_pin;
      if (state == CLEAR) begin
        sram_we <= 1'b1;
        sram_wmask <= 1'b1;
        sram_addr <= clr_cnt;
        sram_din <= '0;
        rd_pin <= 1'b0;
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) begin
          state <= RUN;
          clear_done <= 1'b1;
        end
      end else begin
        sram_we <= accept && req.we;
        sram_wmask <= accept;
        rd_pin <= accept && !req.we;
        if (accept) begin
          sram_addr <= req.addr;
          sram_din <= req.wdata;
        end
      end
    end
  end
  sram22_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rd_cap),
    .din(sram_dout),
    .pop(rsp_ready),
    .dout(rsp_rdata),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_sram22_64x24_ctrl.sv
// tb_sram22_64x24_ctrl: directed bench for the SRAM22 front end with a behavioural macro model
module tb_sram22_64x24_ctrl;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [5:0] req_addr = 0;
  logic [23:0] req_wdata = 0;
  logic req_ready, rsp_valid, clear_done, sram_we, sram_wmask;
  logic [5:0] sram_addr;
  logic [23:0] sram_din, sram_dout, rsp_rdata;
  int vectors = 0, miscompares = 0, tmo = 0, cyc = 0, xerr = 0;
  logic [23:0] mem [64];
  logic seeded = 0;
  logic [23:0] got [$];
  int got_cyc [$];

  sram22_64x24_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .clear_done(clear_done), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro: undefined contents at power-up, dout registered, X on write cycles.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 24'($urandom) | 24'h1;
      seeded <= 1'b1;
    end else if (sram_we && sram_wmask) begin
      mem[sram_addr] <= sram_din;
      sram_dout <= 'x;
    end else sram_dout <= mem[sram_addr];
  end

  always @(negedge clk) begin
    #2;
    if ($isunknown(rsp_rdata)) xerr++;
    if (rsp_valid && rsp_ready) begin
      got.push_back(rsp_rdata);
      got_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic we, input logic [5:0] a, input logic [23:0] d, output int tries);
    logic acc;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; tries = 0;
    do begin
      tries++;
      #1 acc = req_ready;
      @(negedge clk);
    end while (!acc && tries < 50);
    if (!acc) tmo++;
  endtask

  task automatic test_reset;
    logic [23:0] obs [8];
    string nm [8] = '{"req_ready", "rsp_valid", "clear_done", "sram_we", "sram_wmask", "sram_addr", "sram_din", "rsp_rdata"};
    int rise = 0, ready_bad = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    obs = '{24'(req_ready), 24'(rsp_valid), 24'(clear_done), 24'(sram_we), 24'(sram_wmask), 24'(sram_addr), sram_din, rsp_rdata};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs[i] !== 24'h0) begin miscompares++; $display("FAIL reset_%s: got %0h, expected 0", nm[i], obs[i]); end
    end
    rst = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        vectors++;
        if (!(sram_we === 1 && sram_wmask === 1 && sram_addr === 0 && sram_din === 0)) begin
          miscompares++; $display("FAIL clear_first_write: got we=%b mask=%b addr=%0d, expected 1 1 0", sram_we, sram_wmask, sram_addr);
        end
      end
      if (!clear_done && req_ready) ready_bad++;
      if (clear_done) begin rise = i; break; end
    end
    vectors++;
    if (rise !== 64) begin miscompares++; $display("FAIL clear_duration: got %0d, expected 64", rise); end
    vectors++;
    if (ready_bad !== 0) begin miscompares++; $display("FAIL ready_in_clear: got %0d cycles high, expected 0", ready_bad); end
    vectors++;
    if (sram_addr !== 6'd63 || sram_we !== 1'b1) begin miscompares++; $display("FAIL clear_last_addr: got %0d, expected 63", sram_addr); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_clear: got %b, expected 1", req_ready); end
  endtask

  task automatic test_clear_reads;
    int t;
    got.delete(); got_cyc.delete(); rsp_ready = 1;
    send(0, 0, 0, t); send(0, 31, 0, t); send(0, 63, 0, t);
    req_valid = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (got.size() !== 3) begin miscompares++; $display("FAIL clear_read_count: got %0d, expected 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 24'h0) begin miscompares++; $display("FAIL clear_read_%0d: got %0h, expected 0", i, got[i]); end
    end
  endtask

  task automatic test_write_read;
    int t;
    got.delete(); got_cyc.delete(); rsp_ready = 1;
    send(1, 5, 24'hA5A5A5, t); send(0, 5, 0, t);
    req_valid = 0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rd_early_n: got %b, expected 0", rsp_valid); end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rd_early_n1: got %b, expected 0", rsp_valid); end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 24'hA5A5A5) begin
      miscompares++; $display("FAIL wr_rd_latency2: got valid=%b data=%0h, expected 1 a5a5a5", rsp_valid, rsp_rdata);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t, stalls = 0;
    got.delete(); got_cyc.delete(); rsp_ready = 1;
    for (int i = 0; i < 8; i++) send(1, 6'(i), 24'(i * 3), t);
    for (int i = 0; i < 8; i++) begin
      send(0, 6'(i), 0, t);
      if (t != 1) stalls++;
    end
    req_valid = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (stalls !== 0) begin miscompares++; $display("FAIL b2b_ready: got %0d stalls, expected 0", stalls); end
    vectors++;
    if (got.size() !== 8) begin miscompares++; $display("FAIL b2b_count: got %0d, expected 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 24'(i * 3) || got_cyc[i] - got_cyc[0] !== i) begin
        miscompares++; $display("FAIL b2b_rsp_%0d: got %0h at +%0d, expected %0h at +%0d", i, got[i], got_cyc[i] - got_cyc[0], i * 3, i);
      end
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [23:0] exp [5] = '{24'd0, 24'd3, 24'd6, 24'd9, 24'd12};
    got.delete(); got_cyc.delete(); rsp_ready = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1; req_we = 0; req_addr = 6'(n);
      #1 if (req_ready) n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL bp_accepted: got %0d, expected 4", n); end
    req_we = 1; req_addr = 10; req_wdata = 24'h777777;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_write_ready: got %b, expected 1", req_ready); end
    @(negedge clk);
    req_we = 0; req_addr = 4; rsp_ready = 1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_pop_same_cycle: got %b, expected 0", req_ready); end
    @(negedge clk);
    rsp_ready = 0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_recover: got %b, expected 1", req_ready); end
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    repeat (8) @(negedge clk);
    vectors++;
    if (got.size() !== 5) begin miscompares++; $display("FAIL bp_count: got %0d, expected 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin miscompares++; $display("FAIL bp_rsp_%0d: got %0h, expected %0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_mixed;
    int t;
    got.delete(); got_cyc.delete(); rsp_ready = 1;
    send(1, 1, 24'h111111, t); send(0, 1, 0, t); send(1, 1, 24'h222222, t); send(0, 1, 0, t);
    req_valid = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (got.size() !== 2) begin miscompares++; $display("FAIL mix_count: got %0d, expected 2", got.size()); end
    else begin
      vectors++;
      if (got[0] !== 24'h111111 || got[1] !== 24'h222222) begin
        miscompares++; $display("FAIL mix_data: got %0h %0h, expected 111111 222222", got[0], got[1]);
      end
    end
    vectors++;
    if (xerr !== 0) begin miscompares++; $display("FAIL mix_no_x: got %0d unknown samples, expected 0", xerr); end
  endtask

  task automatic test_reset_inflight;
    int t, rise = 0, vhigh = 0;
    got.delete(); got_cyc.delete(); rsp_ready = 0;
    send(0, 1, 0, t); send(0, 5, 0, t); send(0, 1, 0, t);
    rst = 1; req_valid = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (clear_done !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_inflight_state: got done=%b valid=%b, expected 0 0", clear_done, rsp_valid);
    end
    rst = 0; rsp_ready = 1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rsp_valid) vhigh++;
      if (clear_done) begin rise = i; break; end
    end
    vectors++;
    if (rise !== 64) begin miscompares++; $display("FAIL rst_clear_restart: got %0d, expected 64", rise); end
    vectors++;
    if (vhigh !== 0 || got.size() !== 0) begin
      miscompares++; $display("FAIL rst_dropped_rsp: got %0d valid cycles and %0d rsps, expected 0", vhigh, got.size());
    end
    send(0, 1, 0, t); send(0, 5, 0, t);
    req_valid = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (got.size() !== 2) begin miscompares++; $display("FAIL rst_read_count: got %0d, expected 2", got.size()); end
    else begin
      vectors++;
      if (got[0] !== 24'h0 || got[1] !== 24'h0) begin miscompares++; $display("FAIL rst_read_zero: got %0h %0h, expected 0 0", got[0], got[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_mixed();
    test_reset_inflight();
    vectors++;
    if (tmo !== 0) begin miscompares++; $display("FAIL accept_timeout: got %0d, expected 0", tmo); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram22_64x24_ctrl.md
# sram22_64x24_ctrl

Request/response front end for the 64×24 single-port SRAM22 macro, sitting directly upstream of it. Converts a valid/ready request stream (reads and full-word writes) into registered macro pins. Captures the macro's one-cycle read data into a credit-protected response FIFO. After every reset it clears the array to zero, since silicon powers up undefined.

## Interface
- `DATA_WIDTH`, 24, word width; must match the macro.
- `ADDR_WIDTH`, 6, address width; depth = 2^ADDR_WIDTH.
- `RSP_DEPTH`, 4, response FIFO entries; legal range 2–8, power of two.
- `CLEAR_ON_RESET`, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN.

- `clk`  in  1  clock; shared with the macro.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on a `clk` edge when both valid and ready are high.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_WIDTH  read data, in request order.
- `clear_done`  out  1  high once in RUN.
- `sram_we`  out  1  to macro `we`.
- `sram_wmask`  out  1  to macro `wmask`.
- `sram_addr`  out  ADDR_WIDTH  to macro `addr`.
- `sram_din`  out  DATA_WIDTH  to macro `din`.
- `sram_dout`  in  DATA_WIDTH  from macro `dout`.

## Operation
- FSM states:
  - CLEAR: reset entry when `CLEAR_ON_RESET` = 1.
  - RUN: reset entry when `CLEAR_ON_RESET` = 0.
- CLEAR behaviour:
  - A 6-bit counter issues writes of 0 to addresses 0..63, one per cycle, with `sram_wmask` = 1.
  - After the write to address 63 is issued, move to RUN.
  - `req_ready` = 0 and `clear_done` = 0 throughout CLEAR.
- RUN, write request: always accepted. Produces no response.
- RUN, read request: accepted only if `outstanding` < `RSP_DEPTH`.
  - `outstanding` = FIFO count + reads in pin stage + reads in capture stage.
  - All three terms are registered values.
  - A FIFO pop in the same cycle does not free credit.
  - `req_ready` never depends combinationally on `rsp_ready`.
- Pin stage, on accept: `sram_we` = `req_we`, `sram_addr` = `req_addr`, `sram_din` = `req_wdata`, `sram_wmask` = 1.
- Pin stage, idle cycle: `sram_we` = 0, `sram_wmask` = 0, and `sram_addr`/`sram_din` hold their previous values. The macro reads on idle edges; that data is never captured.
- Capture: a read-tag pipeline (2 stages) marks which cycle's `sram_dout` is pushed into the FIFO. Write cycles (`dout` = X) are never captured.
- Ordering:
  - Requests execute strictly in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
- Reset: `rst` high at any time drops all in-flight reads and FIFO contents and restarts CLEAR. No response is emitted for dropped reads.

## Timing
- Reset values:
  - `req_ready` = 0; `rsp_valid` = 0.
  - `clear_done` = 0 (1 if `CLEAR_ON_RESET` = 0).
  - `sram_we` = 0; `sram_wmask` = 0; `sram_addr` = 0; `sram_din` = 0.
  - `rsp_rdata` = 0.
- Clear duration: 64 cycles. `clear_done` and `req_ready` rise on the cycle after the final clear write.
- Read latency: accept at edge N → macro samples at N+1 → FIFO push at N+2 → `rsp_valid` high from N+2. Two cycles minimum.
- Throughput: one request per cycle sustained with `rsp_ready` held high and `RSP_DEPTH` ≥ 4.
- FIFO empty: `rsp_valid` = 0 and `rsp_rdata` holds its last value.
- FIFO full: unreachable by construction. Pushing into a full FIFO is an assertion failure.

## Structure
- Package `sram22_ctrl_pkg`:
  - `DATA_WIDTH` and `ADDR_WIDTH` constants.
  - `ctrl_state_e` {CLEAR, RUN}.
  - Request struct {we, addr, wdata}.
- Sub-module `sram22_rsp_fifo`: parameterized synchronous FIFO with push, pop, count, and `rst`.
- The top level holds the FSM, clear counter, pin registers, tag pipeline and credit logic.

## Test plan
- Reset release: `clear_done` = 0 for 64 cycles, then rises. Reading addresses 0, 31 and 63 returns 0x000000 each.
- Write 0xA5A5A5 to address 5, then read 5 on the next cycle: `rsp_rdata` = 0xA5A5A5 exactly 2 cycles after the read is accepted.
- Back-to-back reads of addresses 0..7 (preloaded with value = addr×3) with `rsp_ready` = 1: responses 0, 3, …, 21 in order, one per cycle, and `req_ready` never drops.
- `rsp_ready` = 0 while issuing reads: exactly 4 accepted, then `req_ready` = 0 for reads. Writes are still accepted. After one pop, `req_ready` recovers on the next cycle.
- Mixed stream W(1, 0x111111), R1, W(1, 0x222222), R1: responses are 0x111111 then 0x222222, and no X ever reaches `rsp_rdata`.
- Assert `rst` with 3 reads in flight: no `rsp_valid` afterwards, CLEAR restarts, and previously written data reads back 0.
